prog_ctr: RTL and testbench
===========================

# prog_ctr

Program counter and sequencing controller for the single-cycle teaching CPU. It consumes the signed jump/branch offset produced by the branch-target lookup table (indexed by the instruction's pointer field) together with decoder control strobes and the ALU zero flag. From these it produces the registered instruction-fetch address. It also provides start/done handshaking with the testbench, a small call/return stack, and a run-cycle counter for performance reporting.

## Interface
- PC_W, 10, width of the instruction address
- OFF_W, 8, width of the signed offset/target from the lookup table
- STACK_D, 4, call/return stack depth (power of 2, ≥2)
- CNT_W, 16, width of the run-cycle counter
- clk  in  1  single system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; forces IDLE state and all outputs to reset values
- start  in  1  begin program from address 0 (level-sampled, acted on in IDLE/DONE)
- halt  in  1  decoder strobe: current instruction is halt
- jump  in  1  unconditional jump
- brz  in  1  branch if zero
- zero  in  1  ALU zero flag for current instruction
- abs_mode  in  1  1 = offset is an absolute target, 0 = relative
- call  in  1  jump and push return address
- ret  in  1  pop return address into PC
- offset  in  OFF_W  signed target/offset from lookup table
- pc  out  PC_W  current fetch address
- running  out  1  high in RUN
- done  out  1  high in DONE
- fault  out  1  sticky stack overflow/underflow flag, valid in DONE
- cycles  out  CNT_W  RUN cycles since last start, saturating

## Operation
- States: IDLE, RUN, DONE.
- Reset values: IDLE; pc=0, running=0, done=0, fault=0, cycles=0, stack pointer=0.
- IDLE: pc held at 0; start=1 → RUN with pc=0, cycles=0, fault=0, stack empty.
- RUN: cycles increments each cycle, saturating at all-ones. Next pc selected by strict priority:
  1. halt → DONE, pc holds.
  2. ret → empty stack: fault=1, DONE, pc holds; otherwise pc=pop.
  3. call → full stack: fault=1, DONE, pc holds; otherwise push pc+1 and pc=target.
  4. jump → pc=target.
  5. brz & zero → pc=target.
  6. otherwise → pc=pc+1.
- Target computation:
  - Relative (abs_mode=0): pc + sign-extended offset, modulo 2^PC_W (wraps both directions).
  - Absolute (abs_mode=1): offset zero-extended, or truncated to PC_W.
  - offset=0 in relative mode is a legal self-loop (lookup-table default entry).
- brz with zero=0 falls through to pc+1.
- pc+1 wraps from 2^PC_W−1 to 0 with no fault.
- start while in RUN is ignored.
- DONE: done=1; pc, cycles and fault hold. start=1 → RUN with the same initialisation as from IDLE.
- Reset in any state, including mid-RUN, takes priority over every other input and empties the stack.

## Timing
- Control inputs are sampled on the rising edge. The new pc is visible the following cycle: one-cycle latency from strobe to fetch address.
- running/done are registered and change in the same cycle the state changes.
- Push and pop take effect in the same edge as the pc update. A ret immediately after a call returns the pushed value.
- The halting instruction's cycle is counted: halt at RUN cycle N yields cycles=N.

## Structure
- Shared package (cpu_pkg) holds the state enum (IDLE/RUN/DONE) and the next-pc select encoding.
- One natural sub-module, ret_stack: STACK_D×PC_W LIFO with push/pop, full/empty outputs and a synchronous reset. All other logic stays in prog_ctr.

## Test plan
- Reset, then start pulse, no strobes for 5 cycles → pc 0,1,2,3,4,5; running=1; cycles=5.
- At pc=20, jump with offset=−12 relative → pc=8. Then brz with offset=6 and zero=0 → pc=9; with zero=1 → pc=15.
- At pc=3, jump with abs_mode=1 and offset=40 → pc=40. At pc=2, jump with offset=−8 relative → pc=1018 (wrap, PC_W=10).
- call at pc=10 with offset=5 → pc=15; ret → pc=11. Five nested calls with STACK_D=4 → fault=1, done=1, pc holds at the 5th call address.
- ret with empty stack → fault=1, done=1. halt at cycle 7 → done=1, cycles=7. start → pc=0, fault=0, cycles restarts.
- reset asserted mid-RUN with jump also asserted → next cycle IDLE, pc=0, all outputs zero, jump ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the teaching-CPU sequencing logic: FSM state codes and next-pc select codes.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_pkg;

  // Controller state. These are plain constants so older tools can still read them.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Source of the next fetch address.
  typedef logic [2:0] pcsel_t;
  localparam pcsel_t SEL_HOLD = 3'd0;  // keep current pc
  localparam pcsel_t SEL_ZERO = 3'd1;  // restart at address 0
  localparam pcsel_t SEL_INC  = 3'd2;  // sequential pc+1
  localparam pcsel_t SEL_TGT  = 3'd3;  // jump/branch/call target
  localparam pcsel_t SEL_POP  = 3'd4;  // return address from stack

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO: DEPTH entries of W bits with push/pop and full/empty flags.
// Latency: push/pop take effect on the clock edge; top_dat is combinational from the current top entry.
// Backpressure: none; push when full and pop when empty are ignored, the caller checks full/empty first.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset (empties the stack)
//   clear           - synchronous empty request (program restart)
//   push, push_dat  - write push_dat on top of the stack
//   pop             - discard the top entry
//   top_dat         - current top entry (meaningful when !empty)
//   full, empty     - occupancy flags
module ret_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_dat,
  output logic [W-1:0] top_dat,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  // sp counts valid entries; one extra bit so "full" is distinguishable from "empty".
  logic [AW:0]   sp;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign wr_idx  = sp[AW-1:0];
  assign rd_idx  = AW'(sp - 1'b1);
  assign full    = (sp == DEPTH_CNT);
  assign empty   = (sp == '0);
  assign top_dat = mem[rd_idx];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sp <= '0;
    end else if (do_push) begin
      sp <= sp + 1'b1;
    end else if (do_pop) begin
      sp <= sp - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read below sp.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !clear) begin
      mem[wr_idx] <= push_dat;
    end
  end

endmodule

// File: rtl/prog_ctr.sv
// Program counter and IDLE/RUN/DONE sequencer with call/return stack and saturating run-cycle counter.
// Latency: one cycle from control strobe to new pc; running/done/fault/cycles are registered.
// Backpressure: none; start is ignored while running, stack overflow/underflow ends the run with fault.
//
// Ports:
//   clk, reset                - clock, synchronous active-high reset (highest priority)
//   start                     - begin program at address 0 when idle or done
//   halt, jump, brz, zero     - decoder strobes and ALU zero flag
//   call, ret                 - subroutine call / return strobes
//   abs_mode, offset          - target is offset (absolute) or pc+offset (relative, signed)
//   pc                        - registered fetch address
//   running, done, fault      - state flags; fault is sticky until the next start
//   cycles                    - RUN cycles since last start, saturating
module prog_ctr
  import cpu_pkg::*;
#(
  parameter int PC_W    = 10,
  parameter int OFF_W   = 8,
  parameter int STACK_D = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt,
  input  logic             jump,
  input  logic             brz,
  input  logic             zero,
  input  logic             abs_mode,
  input  logic             call,
  input  logic             ret,
  input  logic [OFF_W-1:0] offset,
  output logic [PC_W-1:0]  pc,
  output logic             running,
  output logic             done,
  output logic             fault,
  output logic [CNT_W-1:0] cycles
);

  state_t          state;
  state_t          state_nxt;
  pcsel_t          pc_sel;
  logic [PC_W-1:0] pc_nxt;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] off_rel;
  logic [PC_W-1:0] off_abs;
  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] stk_top;
  logic            stk_full;
  logic            stk_empty;
  logic            stk_push;
  logic            stk_pop;
  logic            fault_set;
  logic            init;

  // Size casts do the width work: the signed cast sign-extends (or truncates)
  // for relative mode, the unsigned one zero-extends (or truncates) for absolute.
  // Both sums then wrap naturally modulo 2^PC_W.
  assign off_rel = PC_W'($signed(offset));
  assign off_abs = PC_W'(offset);
  assign tgt     = abs_mode ? off_abs : (pc + off_rel);
  assign pc_inc  = pc + 1'b1;

  always_comb begin
    state_nxt = state;
    pc_sel    = SEL_HOLD;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    fault_set = 1'b0;
    init      = 1'b0;
    case (state)
      ST_RUN: begin
        // Strict priority: halt > ret > call > jump > taken branch > sequential.
        if (halt) begin
          state_nxt = ST_DONE;
        end else if (ret) begin
          if (stk_empty) begin
            fault_set = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            stk_pop = 1'b1;
            pc_sel  = SEL_POP;
          end
        end else if (call) begin
          if (stk_full) begin
            fault_set = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            stk_push = 1'b1;
            pc_sel   = SEL_TGT;
          end
        end else if (jump || (brz && zero)) begin
          pc_sel = SEL_TGT;
        end else begin
          pc_sel = SEL_INC;
        end
      end
      default: begin
        // IDLE and DONE both wait for start; an unused code behaves like IDLE.
        if (start) begin
          init      = 1'b1;
          state_nxt = ST_RUN;
          pc_sel    = SEL_ZERO;
        end
      end
    endcase
  end

  always_comb begin
    pc_nxt = pc;
    case (pc_sel)
      SEL_ZERO: pc_nxt = '0;
      SEL_INC:  pc_nxt = pc_inc;
      SEL_TGT:  pc_nxt = tgt;
      SEL_POP:  pc_nxt = stk_top;
      default:  pc_nxt = pc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      pc      <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
      cycles  <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      running <= (state_nxt == ST_RUN);
      done    <= (state_nxt == ST_DONE);
      if (init) begin
        fault  <= 1'b0;
        cycles <= '0;
      end else if (state == ST_RUN) begin
        // The halting/faulting cycle is itself a RUN cycle and is counted.
        if (fault_set) begin
          fault <= 1'b1;
        end
        if (cycles != '1) begin
          cycles <= cycles + 1'b1;
        end
      end
    end
  end

  ret_stack #(
    .DEPTH (STACK_D),
    .W     (PC_W)
  ) u_ret_stack (
    .clk      (clk),
    .reset    (reset),
    .clear    (init),
    .push     (stk_push),
    .pop      (stk_pop),
    .push_dat (pc_inc),
    .top_dat  (stk_top),
    .full     (stk_full),
    .empty    (stk_empty)
  );

endmodule

// File: tb/tb_prog_ctr.sv
// Self-checking bench for prog_ctr: behavioural reference model plus directed and random stimulus.
// Latency: outputs compared at every falling edge against the model updated at the rising edge.
// Backpressure: n/a.
module tb_prog_ctr;

  localparam int PCW  = 10;
  localparam int PMOD = 1024;
  localparam int CMAX = 255;   // CNT_W = 8 so saturation is reachable quickly
  localparam int DEP  = 4;

  logic           clk = 1'b0;
  logic           reset, start, halt, jump, brz, zero, abs_mode, call, ret;
  logic [7:0]     offset;
  logic [PCW-1:0] pc;
  logic           running, done, fault;
  logic [7:0]     cycles;

  always #5 clk = ~clk;

  prog_ctr #(
    .PC_W    (PCW),
    .OFF_W   (8),
    .STACK_D (DEP),
    .CNT_W   (8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .halt     (halt),
    .jump     (jump),
    .brz      (brz),
    .zero     (zero),
    .abs_mode (abs_mode),
    .call     (call),
    .ret      (ret),
    .offset   (offset),
    .pc       (pc),
    .running  (running),
    .done     (done),
    .fault    (fault),
    .cycles   (cycles)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 finished
  int  m_mode = 0;
  int  m_pc   = 0;
  int  m_cyc  = 0;
  int  m_flt  = 0;
  int  m_stk[$];

  function automatic int wrap(input int v);
    return ((v % PMOD) + PMOD) % PMOD;
  endfunction

  always @(posedge clk) begin
    int t;
    if (reset) begin
      m_mode = 0; m_pc = 0; m_cyc = 0; m_flt = 0; m_stk.delete();
    end else if (m_mode != 1) begin
      if (start) begin
        m_mode = 1; m_pc = 0; m_cyc = 0; m_flt = 0; m_stk.delete();
      end
    end else begin
      m_cyc = (m_cyc >= CMAX) ? CMAX : m_cyc + 1;
      if (abs_mode) t = int'(offset) % PMOD;
      else          t = wrap(m_pc + int'($signed(offset)));
      if (halt) begin
        m_mode = 2;
      end else if (ret) begin
        if (m_stk.size() == 0) begin m_flt = 1; m_mode = 2; end
        else m_pc = m_stk.pop_back();
      end else if (call) begin
        if (m_stk.size() == DEP) begin m_flt = 1; m_mode = 2; end
        else begin m_stk.push_back(wrap(m_pc + 1)); m_pc = t; end
      end else if (jump || (brz && zero)) begin
        m_pc = t;
      end else begin
        m_pc = wrap(m_pc + 1);
      end
    end
  end

  // ---------------- comparison ----------------
  typedef struct {int sel; int val;} exp_t;
  exp_t eq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input int expv);
    n_vec++;
    if (act !== 32'(expv)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      0: return 32'(pc);
      1: return 32'(running);
      2: return 32'(done);
      3: return 32'(fault);
      default: return 32'(cycles);
    endcase
  endfunction

  function automatic string sname(input int sel);
    case (sel)
      0: return "lit_pc";
      1: return "lit_running";
      2: return "lit_done";
      3: return "lit_fault";
      default: return "lit_cycles";
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cmp("pc", 32'(pc), m_pc);
    cmp("running", 32'(running), (m_mode == 1) ? 1 : 0);
    cmp("done", 32'(done), (m_mode == 2) ? 1 : 0);
    cmp("fault", 32'(fault), m_flt);
    cmp("cycles", 32'(cycles), m_cyc);
    while (eq.size() > 0) begin
      e = eq.pop_front();
      cmp(sname(e.sel), pick(e.sel), e.val);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ex(input int sel, input int val);
    exp_t e;
    e.sel = sel;
    e.val = val;
    eq.push_back(e);
  endtask

  task automatic drive(input logic h, input logic r, input logic c, input logic j,
                       input logic b, input logic z, input logic a, input logic [7:0] off);
    halt = h; ret = r; call = c; jump = j; brz = b; zero = z; abs_mode = a; offset = off;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic go();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; idle_in();
    tick();
    ex(0, 0); ex(1, 0); ex(2, 0); ex(3, 0); ex(4, 0);
    tick();
    reset = 1'b0;

    // start, then five plain cycles
    ex(0, 0); ex(1, 1); ex(4, 0);
    go();
    repeat (4) tick();
    ex(0, 5); ex(4, 5);
    tick();

    // relative jump back, branch not taken / taken
    drive(0, 0, 0, 1, 0, 0, 1, 8'd20); tick();
    drive(0, 0, 0, 1, 0, 0, 0, 8'hF4); ex(0, 8); tick();
    drive(0, 0, 0, 0, 1, 0, 0, 8'd6);  ex(0, 9); tick();
    drive(0, 0, 0, 0, 1, 1, 0, 8'd6);  ex(0, 15); tick();

    // absolute jump and negative wrap
    drive(0, 0, 0, 1, 0, 0, 1, 8'd3);  tick();
    drive(0, 0, 0, 1, 0, 0, 1, 8'd40); ex(0, 40); tick();
    drive(0, 0, 0, 1, 0, 0, 1, 8'd2);  tick();
    drive(0, 0, 0, 1, 0, 0, 0, 8'hF8); ex(0, 1018); tick();

    // call / return, then overflow on the fifth nested call
    drive(0, 0, 0, 1, 0, 0, 1, 8'd10); tick();
    drive(0, 0, 1, 0, 0, 0, 0, 8'd5);  ex(0, 15); tick();
    drive(0, 1, 0, 0, 0, 0, 0, 8'd0);  ex(0, 11); tick();
    drive(0, 0, 1, 0, 0, 0, 0, 8'd5);
    repeat (4) tick();
    ex(0, 31); ex(3, 1); ex(2, 1); ex(1, 0);
    tick();
    idle_in();

    // restart clears fault; ret on empty stack faults
    ex(0, 0); ex(3, 0); ex(4, 0); ex(1, 1);
    go();
    drive(0, 1, 0, 0, 0, 0, 0, 8'd0); ex(3, 1); ex(2, 1); ex(0, 0); tick();
    idle_in();

    // halt in the 7th RUN cycle
    go();
    repeat (6) tick();
    drive(1, 0, 0, 0, 0, 0, 0, 8'd0); ex(4, 7); ex(2, 1); ex(0, 6); tick();
    idle_in();

    // long run: counter saturates, pc keeps counting
    go();
    repeat (299) tick();
    ex(4, 255); ex(0, 300);
    tick();

    // start while running is ignored
    start = 1'b1; ex(0, 301); ex(1, 1); tick(); start = 1'b0;

    // reset mid-run with a jump pending
    reset = 1'b1; drive(0, 0, 0, 1, 0, 0, 1, 8'd50);
    ex(0, 0); ex(1, 0); ex(2, 0); ex(3, 0); ex(4, 0);
    tick();
    reset = 1'b0; idle_in();
    ex(0, 0); ex(1, 0);
    tick();

    // random phase
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(299) == 0);
      start    = ($urandom_range(9) == 0);
      halt     = ($urandom_range(39) == 0);
      ret      = ($urandom_range(9) == 0);
      call     = ($urandom_range(7) == 0);
      jump     = ($urandom_range(5) == 0);
      brz      = ($urandom_range(3) == 0);
      zero     = ($urandom_range(1) == 1);
      abs_mode = ($urandom_range(1) == 1);
      offset   = 8'($urandom);
      tick();
    end

    reset = 1'b0; start = 1'b0; idle_in();
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
